// File: rtl/sdff_led_reg.sv
// Scannable register bank with per-bit LED drive: scan-muxed D flops chained LSB->MSB,
// load enable, synchronous reset to RESET_VALUE, and SHOW/OFF/LAMP/BLINK LED modes.
module sdff_led_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               BLINK_DIV   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scan_en_i,
  input  logic             scan_d_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       led_mode_i,
  output logic [WIDTH-1:0] q_o,
  output logic             scan_q_o,
  output logic [WIDTH-1:0] led_o
);

  localparam logic [1:0] LED_SHOW  = 2'b00;
  localparam logic [1:0] LED_OFF   = 2'b01;
  localparam logic [1:0] LED_LAMP  = 2'b10;
  localparam logic [1:0] LED_BLINK = 2'b11;

  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     shift_nxt;
  logic [BLINK_DIV-1:0] div;
  logic                 blink;

  // A one-bit chain has nothing to shift up; the scan input simply replaces the bit.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign shift_nxt = scan_d_i;
    end else begin : g_shift_chain
      assign shift_nxt = {q[WIDTH-2:0], scan_d_i};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= RESET_VALUE;
    end else if (scan_en_i) begin
      q <= shift_nxt;
    end else if (en_i) begin
      q <= d_i;
    end
  end

  // Free-running prescaler; its MSB gives a 50 % duty blink.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div <= '0;
    end else begin
      div <= div + BLINK_DIV'(1);
    end
  end

  assign blink = div[BLINK_DIV-1];

  always_comb begin
    led_o = q;
    case (led_mode_i)
      LED_SHOW:  led_o = q;
      LED_OFF:   led_o = '0;
      LED_LAMP:  led_o = '1;
      LED_BLINK: led_o = q & {WIDTH{blink}};
      default:   led_o = q;
    endcase
  end

  assign q_o      = q;
  assign scan_q_o = q[WIDTH-1];

endmodule

// File: tb/tb_sdff_led_reg.sv
// Directed bench for sdff_led_reg (WIDTH=8, RESET_VALUE=0xA5, BLINK_DIV=4).
module tb_sdff_led_reg;

  logic       clk;
  logic       rst;
  logic       scan_en;
  logic       scan_d;
  logic       en;
  logic [7:0] d;
  logic [1:0] led_mode;
  logic [7:0] q;
  logic       scan_q;
  logic [7:0] led;

  int n_cmp = 0;
  int n_err = 0;

  sdff_led_reg #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5),
    .BLINK_DIV  (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scan_en_i (scan_en),
    .scan_d_i  (scan_d),
    .en_i      (en),
    .d_i       (d),
    .led_mode_i(led_mode),
    .q_o       (q),
    .scan_q_o  (scan_q),
    .led_o     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q  [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB1};
  logic [7:0] sbits      = 8'b1011_0001;
  logic [7:0] rt_bits    = 8'b1001_0110;

  initial begin
    rst = 1'b1; scan_en = 1'b0; scan_d = 1'b0; en = 1'b1; d = 8'hFF; led_mode = 2'b00;

    // Reset dominates a concurrent load
    tick();
    check("reset_q", q, 8'hA5);
    check("reset_scan_q", {7'b0, scan_q}, 8'h01);
    check("reset_led_show", led, 8'hA5);
    led_mode = 2'b11; #1;
    check("reset_led_blink", led, 8'h00);
    led_mode = 2'b00;

    // Load then hold
    rst = 1'b0; en = 1'b1; d = 8'h3C;
    tick();
    check("load_q", q, 8'h3C);
    check("load_led", led, 8'h3C);
    en = 1'b0; d = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_q", q, 8'h3C);
    end
    led_mode = 2'b01; #1;
    check("mode_off", led, 8'h00);
    led_mode = 2'b10; #1;
    check("mode_lamp", led, 8'hFF);
    check("mode_q_untouched", q, 8'h3C);
    led_mode = 2'b00;

    // Scan shift with a competing load
    en = 1'b1; d = 8'h00;
    tick();
    check("clear_q", q, 8'h00);
    scan_en = 1'b1; en = 1'b1; d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      scan_d = sbits[7-i];
      tick();
      check("shift_q", q, exp_q[i]);
      check("shift_scan_q", {7'b0, scan_q}, (i == 7) ? 8'h01 : 8'h00);
    end

    // Unload/reload round trip
    scan_en = 1'b0; en = 1'b1; d = 8'h96;
    tick();
    check("rt_load", q, 8'h96);
    scan_en = 1'b1; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("rt_scan_q", {7'b0, scan_q}, {7'b0, rt_bits[7-i]});
      scan_d = scan_q;
      tick();
    end
    check("rt_q", q, 8'h96);

    // LED modes on 0x5A
    scan_en = 1'b0; en = 1'b1; d = 8'h5A;
    tick();
    en = 1'b0;
    led_mode = 2'b00; #1;
    check("led_show", led, 8'h5A);
    led_mode = 2'b01; #1;
    check("led_off", led, 8'h00);
    led_mode = 2'b10; #1;
    check("led_lamp", led, 8'hFF);

    // Blink from reset, reset pulsed at cycle 11
    led_mode = 2'b11; rst = 1'b1;
    tick();
    check("blink_c0", led, 8'h00);
    rst = 1'b0; en = 1'b1; d = 8'h5A;
    tick();
    check("blink_c1", led, 8'h00);
    en = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      check("blink_run", led, (c >= 8) ? 8'h5A : 8'h00);
    end
    rst = 1'b1;
    tick();
    check("blink_rst_q", q, 8'hA5);
    check("blink_rst_led", led, 8'h00);
    rst = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      check("blink_after_rst", led, (c >= 8 && c < 16) ? 8'hA5 : 8'h00);
    end

    // Reset in the middle of a scan shift
    led_mode = 2'b00; scan_en = 1'b1; scan_d = 1'b1;
    tick();
    check("mscan_1", q, 8'h4B);
    tick();
    check("mscan_2", q, 8'h97);
    rst = 1'b1;
    tick();
    check("mscan_rst", q, 8'hA5);
    check("mscan_rst_scan_q", {7'b0, scan_q}, 8'h01);
    rst = 1'b0; scan_d = 1'b0;
    tick();
    check("mscan_resume", q, 8'h4A);
    check("mscan_resume_scan_q", {7'b0, scan_q}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
